// File: rtl/sipo_pixel_capture.sv
// Serial-to-parallel receiver for the VGA pixel stream: rebuilds MSB-first bytes inside the
// delayed display window and queues them in a first-word-fall-through FIFO. Optional: SIPO_PARTIAL_FLUSH_EN.
module sipo_pixel_capture #(
  parameter int ALIGN_DELAY = 1,
  parameter int ADDR_W      = 4
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       display_area,
  input  logic       serial_input,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] line_bytes,
  output logic       overflow,
  input  logic       clear_overflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic              w_win;
  logic              w_win_rise;
  logic              w_complete;
  logic [7:0]        w_byte;
  logic              w_push;
  logic [7:0]        w_push_data;
  logic              w_empty;
  logic              w_full;
  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_drop;

  logic              r_win_prev;
  logic [2:0]        r_cnt;
  logic [6:0]        r_shift;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [7:0]        r_line_bytes;
  logic              r_overflow;
  logic [7:0]        r_mem [0:DEPTH-1];

  // Window alignment: display_area delayed to match the serializer's output latency.
  generate
    if (ALIGN_DELAY == 0) begin : g_no_delay
      assign w_win = display_area;
    end else begin : g_delay
      logic [ALIGN_DELAY-1:0] r_dly;
      for (genvar gi = 0; gi < ALIGN_DELAY; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge vga_clk or posedge reset) begin
            if (reset) r_dly[gi] <= 1'b0;
            else       r_dly[gi] <= display_area;
          end
        end else begin : g_next
          always_ff @(posedge vga_clk or posedge reset) begin
            if (reset) r_dly[gi] <= 1'b0;
            else       r_dly[gi] <= r_dly[gi-1];
          end
        end
      end
      assign w_win = r_dly[ALIGN_DELAY-1];
    end
  endgenerate

  assign w_win_rise = w_win & ~r_win_prev;
  assign w_complete = w_win && (r_cnt == 3'd7);
  assign w_byte     = {r_shift, serial_input};

`ifdef SIPO_PARTIAL_FLUSH_EN
  logic       w_flush;
  logic [7:0] w_partial;
  // Counter is only non-zero with win low on the first cycle after the window closes.
  assign w_flush   = !w_win && (r_cnt != 3'd0);
  assign w_partial = {r_shift, 1'b0} << (3'd7 - r_cnt);
`endif

  always_comb begin
    w_push      = w_complete;
    w_push_data = w_byte;
`ifdef SIPO_PARTIAL_FLUSH_EN
    if (w_flush) begin
      w_push      = 1'b1;
      w_push_data = w_partial;
    end
`endif
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_rd_en = ~w_empty & out_ready;
  // A read on the same edge frees a slot, so a full FIFO still accepts the write.
  assign w_wr_en = w_push & (~w_full | w_rd_en);
  assign w_drop  = w_push & w_full & ~w_rd_en;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_win_prev   <= 1'b0;
      r_cnt        <= 3'd0;
      r_shift      <= 7'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_line_bytes <= 8'd0;
      r_overflow   <= 1'b0;
    end else begin
      r_win_prev <= w_win;
      if (w_win) begin
        r_shift <= w_byte[6:0];
        r_cnt   <= r_cnt + 3'd1;
      end else begin
        r_cnt <= 3'd0;
      end
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_win_rise)
        r_line_bytes <= 8'd0;
      else if (w_push && (r_line_bytes != 8'hFF))
        r_line_bytes <= r_line_bytes + 8'd1;
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clear_overflow)
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_push_data;
  end

  assign out_valid  = ~w_empty;
  assign out_data   = w_empty ? 8'd0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign line_bytes = r_line_bytes;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_sipo_pixel_capture.sv
// Directed bench for sipo_pixel_capture (ALIGN_DELAY=1, 4-entry FIFO); exercises
// SIPO_PARTIAL_FLUSH_EN expectations when that macro is defined.
module tb_sipo_pixel_capture;

  localparam int ALIGN_DELAY = 1;
  localparam int ADDR_W      = 2;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       display_area = 1'b0;
  logic       serial_input = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [7:0] line_bytes;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  sipo_pixel_capture #(.ALIGN_DELAY(ALIGN_DELAY), .ADDR_W(ADDR_W)) dut (
    .vga_clk(vga_clk),
    .reset(reset),
    .display_area(display_area),
    .serial_input(serial_input),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .line_bytes(line_bytes),
    .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic start_window;
    display_area = 1'b1;
    tick();
  endtask

  // Sends one byte MSB first; on the last byte of a window display_area drops with bit 0.
  task automatic send_byte(input logic [7:0] b, input bit last, input bit ready_last);
    for (int i = 7; i >= 0; i--) begin
      serial_input = b[i];
      if (last && i == 0) begin
        display_area = 1'b0;
        if (ready_last) out_ready = 1'b1;
      end
      tick();
    end
    serial_input = 1'b0;
    if (ready_last) out_ready = 1'b0;
    $display("sent byte 0x%02h line_bytes=%0d", b, line_bytes);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    check({tag, "_data"}, out_data, exp);
    $display("popped 0x%02h (%s)", out_data, tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_valid", {7'd0, out_valid}, 8'd0);
    check("rst_data", out_data, 8'h00);
    check("rst_line", line_bytes, 8'd0);
    check("rst_ovf", {7'd0, overflow}, 8'd0);
    reset = 1'b0;
    tick();

    // Single byte with consumer always ready: out_valid is a one-cycle pulse
    out_ready = 1'b1;
    start_window();
    send_byte(8'hA5, 1'b1, 1'b0);
    out_ready = 1'b1;
    check("b1_valid", {7'd0, out_valid}, 8'd1);
    check("b1_data", out_data, 8'hA5);
    check("b1_line", line_bytes, 8'd1);
    tick();
    check("b1_valid_drop", {7'd0, out_valid}, 8'd0);
    out_ready = 1'b0;

    // Four bytes buffered, then drained in order
    start_window();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    check("q4_line", line_bytes, 8'd4);
    check("q4_ovf", {7'd0, overflow}, 8'd0);
    pop_expect("q4_0", 8'h00);
    pop_expect("q4_1", 8'hFF);
    pop_expect("q4_2", 8'h3C);
    pop_expect("q4_3", 8'hC3);
    check("q4_empty", {7'd0, out_valid}, 8'd0);

    // Fifth byte into a full FIFO is dropped
    start_window();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    check("ovf_set", {7'd0, overflow}, 8'd1);
    pop_expect("ovf_0", 8'h11);
    pop_expect("ovf_1", 8'h22);
    pop_expect("ovf_2", 8'h33);
    pop_expect("ovf_3", 8'h44);
    check("ovf_empty", {7'd0, out_valid}, 8'd0);
    check("ovf_sticky", {7'd0, overflow}, 8'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_clear", {7'd0, overflow}, 8'd0);

    // Same stream, but a read coincides with the fifth completion
    start_window();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    send_byte(8'h55, 1'b1, 1'b1);
    check("rw_ovf", {7'd0, overflow}, 8'd0);
    pop_expect("rw_0", 8'h22);
    pop_expect("rw_1", 8'h33);
    pop_expect("rw_2", 8'h44);
    pop_expect("rw_3", 8'h55);
    check("rw_empty", {7'd0, out_valid}, 8'd0);

    // Window closes after three bits 1,1,0
    start_window();
    serial_input = 1'b1; tick();
    serial_input = 1'b1; tick();
    serial_input = 1'b0; display_area = 1'b0; tick();
    tick();
`ifdef SIPO_PARTIAL_FLUSH_EN
    check("part_line", line_bytes, 8'd1);
    pop_expect("part", 8'hC0);
`else
    check("part_valid", {7'd0, out_valid}, 8'd0);
    check("part_line", line_bytes, 8'd0);
`endif

    // Reset mid-byte with three entries queued
    start_window();
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    check("pre_rst_line", line_bytes, 8'd3);
    start_window();
    serial_input = 1'b1; tick();
    serial_input = 1'b0; tick();
    serial_input = 1'b1; tick();
    reset = 1'b1;
    display_area = 1'b0;
    #2;
    check("mid_rst_valid", {7'd0, out_valid}, 8'd0);
    check("mid_rst_line", line_bytes, 8'd0);
    check("mid_rst_ovf", {7'd0, overflow}, 8'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_valid", {7'd0, out_valid}, 8'd0);
    start_window();
    send_byte(8'h5A, 1'b1, 1'b0);
    check("post_rst_line", line_bytes, 8'd1);
    pop_expect("post_rst", 8'h5A);
    check("post_rst_empty", {7'd0, out_valid}, 8'd0);

    // Two windows: line_bytes holds between windows and clears on win rise
    start_window();
    send_byte(8'h81, 1'b0, 1'b0);
    send_byte(8'h7E, 1'b1, 1'b0);
    check("w1_line", line_bytes, 8'd2);
    tick();
    tick();
    check("w1_hold", line_bytes, 8'd2);
    start_window();
    check("w2_before_rise", line_bytes, 8'd2);
    send_byte(8'hE7, 1'b1, 1'b0);
    check("w2_line", line_bytes, 8'd1);
    pop_expect("w_0", 8'h81);
    pop_expect("w_1", 8'h7E);
    pop_expect("w_2", 8'hE7);
    check("w_empty", {7'd0, out_valid}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
